// File: rtl/serial_adder_fsm.sv
// ----------------------------------------------------------------------------
// serial_adder_fsm
//
// Bit-serial ripple adder. A single full-adder cell and a carry flip-flop sum
// two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
// The result is registered and held until the next operation completes.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   defined   -> extra 'sub' input. When sub=1 at the accepting edge, the
//                block computes a - b as a + ~b + 1 and ignores c_in.
//                c_out=1 then means "no borrow" (a >= b).
//   undefined -> add-only; no 'sub' port.
//
// Handshake (valid/ready):
//   'start' is a request sampled only while idle ('busy' low). The edge on
//   which start=1 is seen in IDLE accepts the operands (edge E0). start
//   while busy is dropped, not queued. 'done' pulses for exactly one cycle
//   WIDTH edges after E0; sum/c_out are valid from then until the next
//   completion. start may be high in the done cycle and is accepted.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   start      in   1      request, sampled only in IDLE
//   a          in   WIDTH  operand A, captured at E0
//   b          in   WIDTH  operand B, captured at E0
//   c_in       in   1      carry-in, captured at E0
//   sub        in   1      (SERIAL_ADDER_SUB_EN only) subtract select
//   busy       out  1      operation in progress
//   done       out  1      one-cycle completion pulse
//   sum        out  WIDTH  registered result
//   c_out      out  1      registered carry-out
//   state_dbg  out  1      current FSM state (0 = IDLE, 1 = RUN)
// ----------------------------------------------------------------------------
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             done_q, done_d;

    // Operand B and the initial carry as they enter the shift path.
    logic [WIDTH-1:0] load_b;
    logic             load_carry;
    // Full-adder cell outputs for the current bit position.
    logic             fa_s;
    logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B, inject a 1 as carry.
    assign load_b     = sub ? ~b : b;
    assign load_carry = sub ? 1'b1 : c_in;
`else
    assign load_b     = b;
    assign load_carry = c_in;
`endif

    assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = load_b;
                    carry_d = load_carry;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Each sum bit enters at the MSB, so after WIDTH shifts the
                // first (LSB) bit has reached position 0.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    c_out_d = fa_c;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign state_dbg = state_q;

endmodule
